// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   WIDTH-bit register. It supports the following operations:
//   - async reset
//   - synchronous clear
//   - clock enable
//   - hold, parallel load, logical shift left/right and rotate left/right
//   A saturating shift counter and a one-cycle done pulse are included,
//   so the block can serve as a serializer/deserializer.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sclr       synchronous clear (beats en/mode)
//   en         enable for mode operations
//   mode       000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 11x hold
//   d          parallel load data
//   ser_in_l   bit entering q[0] on shift left
//   ser_in_r   bit entering q[WIDTH-1] on shift right
//   q          register contents
//   ser_out_l  q[WIDTH-1]
//   ser_out_r  q[0]
//   shift_cnt  shifts/rotates since last load/clear, saturates at WIDTH
//   done       one-cycle pulse when shift_cnt reaches WIDTH
module universal_shift_reg #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  localparam int unsigned          CntW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic [CntW-1:0]  shift_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101
  } mode_e;

  localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q,    w_q_d;
  logic [CntW-1:0]  r_cnt,  w_cnt_d;
  logic             r_done, w_done_d;
  logic             w_shifting;

  always_comb begin
    w_q_d      = r_q;
    w_shifting = 1'b0;
    // Unlisted or unknown mode values fall to default and hold.
    case (mode)
      ModeLoad: w_q_d = d;
      ModeShl: begin
        w_q_d      = {r_q[WIDTH-2:0], ser_in_l};
        w_shifting = 1'b1;
      end
      ModeShr: begin
        w_q_d      = {ser_in_r, r_q[WIDTH-1:1]};
        w_shifting = 1'b1;
      end
      ModeRol: begin
        w_q_d      = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_shifting = 1'b1;
      end
      ModeRor: begin
        w_q_d      = {r_q[0], r_q[WIDTH-1:1]};
        w_shifting = 1'b1;
      end
      default: w_q_d = r_q;
    endcase
  end

  always_comb begin
    w_cnt_d  = r_cnt;
    w_done_d = 1'b0;
    if (mode == ModeLoad) begin
      w_cnt_d = '0;
    end else if (w_shifting && (r_cnt != CntMax)) begin
      w_cnt_d  = r_cnt + CntW'(1);
      // Pulse only on the WIDTH-1 -> WIDTH transition, never while saturated.
      w_done_d = (r_cnt == CntLast);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= RESET_VALUE;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (sclr) begin
      r_q    <= RESET_VALUE;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (en) begin
      r_q    <= w_q_d;
      r_cnt  <= w_cnt_d;
      r_done <= w_done_d;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign q         = r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign shift_cnt = r_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VALUE=0).
module tb_universal_shift_reg;

  localparam int unsigned Width = 8;
  localparam int unsigned CntW  = $clog2(Width + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             sclr;
  logic             en;
  logic [2:0]       mode;
  logic [Width-1:0] d;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [Width-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic [CntW-1:0]  shift_cnt;
  logic             done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  universal_shift_reg #(
    .WIDTH      (Width),
    .RESET_VALUE(8'h00)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .sclr     (sclr),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .q        (q),
    .ser_out_l(ser_out_l),
    .ser_out_r(ser_out_r),
    .shift_cnt(shift_cnt),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flag X on mode, clock one edge, then settle past the edge for sampling.
  task automatic step();
    if (!rst) check("mode_known", 64'($isunknown(mode)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] data);
    en   = 1'b1;
    mode = m;
    d    = data;
    step();
  endtask

  task automatic chk_state(input string tag, input logic [7:0] eq, input int ec, input logic ed);
    check({tag, "_q"}, 64'(q), 64'(eq));
    check({tag, "_cnt"}, 64'(shift_cnt), 64'(ec));
    check({tag, "_done"}, 64'(done), 64'(ed));
  endtask

  logic [7:0] shl_exp [8] = '{8'h69, 8'hD3, 8'hA7, 8'h4F, 8'h9F, 8'h3F, 8'h7F, 8'hFF};
  logic [7:0] ror_exp [3] = '{8'hC0, 8'h60, 8'h30};

  initial begin
    rst = 1'b1; sclr = 1'b0; en = 1'b0; mode = 3'b000; d = '0;
    ser_in_l = 1'b0; ser_in_r = 1'b0;
    #12;
    chk_state("por", 8'h00, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset between edges.
    op(3'b001, 8'hA5);
    check("ld_a5", 64'(q), 64'hA5);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_state("arst_now", 8'h00, 0, 1'b0);
    step();
    chk_state("arst_hold", 8'h00, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Load and serial outputs.
    op(3'b001, 8'hB4);
    chk_state("ld_b4", 8'hB4, 0, 1'b0);
    check("sol", 64'(ser_out_l), 64'd1);
    check("sor", 64'(ser_out_r), 64'd0);

    // Shift left eight times with ser_in_l=1, then a ninth at saturation.
    ser_in_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op(3'b010, 8'h00);
      chk_state($sformatf("shl%0d", i + 1), shl_exp[i], i + 1, i == 7);
    end
    op(3'b010, 8'h00);
    chk_state("shl9", 8'hFF, 8, 1'b0);

    // Rotate right from 81, then disable.
    op(3'b001, 8'h81);
    for (int i = 0; i < 3; i++) begin
      op(3'b101, 8'h00);
      check($sformatf("ror%0d", i + 1), 64'(q), 64'(ror_exp[i]));
    end
    check("ror_cnt", 64'(shift_cnt), 64'd3);
    en = 1'b0; mode = 3'b010;
    step();
    step();
    chk_state("en0", 8'h30, 3, 1'b0);

    // Reserved mode holds; rotate left and shift right paths.
    op(3'b110, 8'h00);
    chk_state("rsvd", 8'h30, 3, 1'b0);
    op(3'b001, 8'h81);
    op(3'b100, 8'h00);
    chk_state("rol", 8'h03, 1, 1'b0);
    ser_in_r = 1'b1;
    op(3'b011, 8'h00);
    chk_state("shr", 8'h81, 2, 1'b0);

    // Synchronous clear beats a simultaneous load.
    op(3'b001, 8'h3C);
    sclr = 1'b1;
    op(3'b001, 8'hFF);
    chk_state("sclr", 8'h00, 0, 1'b0);
    sclr = 1'b0;

    // Load on the would-be eighth shift edge suppresses done.
    ser_in_l = 1'b0;
    op(3'b001, 8'h01);
    for (int i = 0; i < 7; i++) op(3'b010, 8'h00);
    chk_state("shl7", 8'h80, 7, 1'b0);
    op(3'b001, 8'h5A);
    chk_state("ld8", 8'h5A, 0, 1'b0);
    en = 1'b0;
    step();
    check("ld8_nodone", 64'(done), 64'd0);

    // Reset mid-sequence aborts with no done.
    op(3'b001, 8'hFF);
    for (int i = 0; i < 5; i++) op(3'b100, 8'h00);
    check("rol5_cnt", 64'(shift_cnt), 64'd5);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 chk_state("arst_mid", 8'h00, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_done%0d", i), 64'(done), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with asynchronous active-high reset, synchronous clear, clock enable and selectable mode (hold, parallel load, logical shift left/right, rotate left/right).
- Includes a shift counter and a one-cycle done pulse, so it can serve as a serializer/deserializer building block in later designs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q by async reset and by sclr.

Ports:
- clk  input  1  clock; all sequential state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; acts immediately without waiting for clk.
- sclr  input  1  synchronous clear, active-high; sampled on the clk rising edge.
- en  input  1  clock enable for mode operations.
- mode  input  3  000 hold, 001 load, 010 shift left, 011 shift right, 100 rotate left, 101 rotate right, 110/111 reserved (hold).
- d  input  WIDTH  parallel load data.
- ser_in_l  input  1  serial input entering bit 0 on shift left.
- ser_in_r  input  1  serial input entering bit WIDTH-1 on shift right.
- q  output  WIDTH  register contents.
- ser_out_l  output  1  equals q[WIDTH-1] (combinational from q).
- ser_out_r  output  1  equals q[0] (combinational from q).
- shift_cnt  output  $clog2(WIDTH+1)  shifts/rotates since last load/clear; saturates at WIDTH.
- done  output  1  registered one-cycle pulse when shift_cnt reaches WIDTH.

Behaviour:
- Async reset: while rst=1, q=RESET_VALUE, shift_cnt=0, done=0, immediately and independent of clk. The first operation occurs on the first rising edge after rst deasserts.
- Priority on each rising edge: rst > sclr > en.
- sclr=1 (regardless of en or mode): q<=RESET_VALUE, shift_cnt<=0, done<=0.
- en=0 with sclr=0: q and shift_cnt hold; done<=0.
- en=1, per mode:
  - 000 or 110/111: hold.
  - 001 load: q<=d.
  - 010 shift left: q<={q[WIDTH-2:0], ser_in_l}.
  - 011 shift right: q<={ser_in_r, q[WIDTH-1:1]}.
  - 100 rotate left: q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q<={q[0], q[WIDTH-1:1]}.
- Counter:
  - Load resets shift_cnt to 0.
  - Each enabled shift or rotate increments shift_cnt by 1, saturating at WIDTH with no wrap.
  - Hold and reserved modes leave shift_cnt unchanged.
- done is 1 in exactly the cycle following the edge where shift_cnt went from WIDTH-1 to WIDTH; otherwise 0.
  - Further shifts at saturation produce no additional done.
  - A load performed on the same edge that would otherwise complete the count takes precedence: shift_cnt=0, no done.
- Latency: q, shift_cnt and done update one clock after inputs are sampled. ser_out_l/ser_out_r follow q with zero added latency.
- Reset mid-operation: rst asserted during a shift sequence aborts it. q=RESET_VALUE, shift_cnt=0, and no done pulse is generated.
- Unknown mode bits: treated as hold (no X propagation into q). The bench flags X on mode as an error.

Test Plan (WIDTH=8, RESET_VALUE=8'h00):
- Assert rst between clock edges while q=8'hA5 -> q=8'h00, shift_cnt=0, done=0 before the next edge; stays so while rst=1.
- Load d=8'hB4 (en=1, mode=001) -> next cycle q=8'hB4, shift_cnt=0, ser_out_l=1, ser_out_r=0.
- From 8'hB4, 8 cycles of shift left with ser_in_l=1 -> q=8'h69, 8'hD3, 8'hA7, 8'h4F, 8'h9F, 8'h3F, 8'h7F, 8'hFF; done=1 only in the cycle after the 8th shift (shift_cnt=8); a 9th shift gives shift_cnt=8, done=0.
- Load 8'h81, then rotate right 3 times -> q=8'hC0, 8'h60, 8'h30; shift_cnt=3. Follow with en=0 for 2 cycles -> q=8'h30 and shift_cnt=3 unchanged.
- q=8'h3C, sclr=1 together with en=1 and mode=001, d=8'hFF -> q=8'h00 (sclr wins), shift_cnt=0.
- After 7 shifts, load on the 8th edge -> shift_cnt=0, no done pulse. After 5 shifts, assert rst -> q=8'h00, shift_cnt=0, done never asserts.
